// File: rtl/spike_word_packer.sv
// Packs a serial spike-bit stream into DATA_WIDTH-bit words with fill/ones counts.
// Handshakes use valid/ready on both sides: a transfer happens on a rising edge where valid and ready are both 1.
module spike_word_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  s_clk,
    input  logic                  s_rst_n,
    input  logic                  i_spike,
    input  logic                  i_spike_valid,
    input  logic                  i_spike_last,
    output logic                  o_spike_ready,
    output logic [DATA_WIDTH-1:0] o_Spikesdata,
    output logic                  o_Spikesdata_valid,
    input  logic                  i_Spikesdata_ready,
    output logic                  o_Spikesdata_last,
    output logic [CNT_WIDTH-1:0]  o_word_fill,
    output logic [CNT_WIDTH-1:0]  o_word_ones
);

    logic [DATA_WIDTH-1:0] asm_word_q, asm_word_d;
    logic [CNT_WIDTH-1:0]  asm_fill_q, asm_fill_d;
    logic [CNT_WIDTH-1:0]  asm_ones_q, asm_ones_d;

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [CNT_WIDTH-1:0]  out_fill_q, out_fill_d;
    logic [CNT_WIDTH-1:0]  out_ones_q, out_ones_d;

    logic                  accept;
    logic                  close;
    logic [CNT_WIDTH-1:0]  next_fill;
    logic [CNT_WIDTH-1:0]  next_ones;
    logic [DATA_WIDTH-1:0] merged_word;

    assign o_spike_ready = ~out_valid_q | i_Spikesdata_ready;
    assign accept        = i_spike_valid & o_spike_ready;
    assign next_fill     = asm_fill_q + CNT_WIDTH'(1);
    assign next_ones     = asm_ones_q + CNT_WIDTH'(i_spike);
    assign close         = accept & (i_spike_last | (next_fill == CNT_WIDTH'(DATA_WIDTH)));

    // Assembly word with the incoming bit placed at the fill position; bits above it are zero.
    always_comb begin
        merged_word = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (CNT_WIDTH'(i) < asm_fill_q) begin
                merged_word[i] = asm_word_q[i];
            end else if (CNT_WIDTH'(i) == asm_fill_q) begin
                merged_word[i] = i_spike;
            end
        end
    end

    always_comb begin
        asm_word_d  = asm_word_q;
        asm_fill_d  = asm_fill_q;
        asm_ones_d  = asm_ones_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_fill_d  = out_fill_q;
        out_ones_d  = out_ones_q;

        if (accept) begin
            if (close) begin
                asm_word_d = '0;
                asm_fill_d = '0;
                asm_ones_d = '0;
            end else begin
                asm_word_d = merged_word;
                asm_fill_d = next_fill;
                asm_ones_d = next_ones;
            end
        end

        // A close can only happen while the output slot is free or draining, so loading never overwrites a held word.
        if (close) begin
            out_data_d  = merged_word;
            out_valid_d = 1'b1;
            out_last_d  = i_spike_last;
            out_fill_d  = next_fill;
            out_ones_d  = next_ones;
        end else if (out_valid_q && i_Spikesdata_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            asm_word_q  <= '0;
            asm_fill_q  <= '0;
            asm_ones_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_fill_q  <= '0;
            out_ones_q  <= '0;
        end else begin
            asm_word_q  <= asm_word_d;
            asm_fill_q  <= asm_fill_d;
            asm_ones_q  <= asm_ones_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_fill_q  <= out_fill_d;
            out_ones_q  <= out_ones_d;
        end
    end

    assign o_Spikesdata       = out_data_q;
    assign o_Spikesdata_valid = out_valid_q;
    assign o_Spikesdata_last  = out_last_q;
    assign o_word_fill        = out_fill_q;
    assign o_word_ones        = out_ones_q;

endmodule

// File: tb/tb_spike_word_packer.sv
// Bench for spike_word_packer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_spike_word_packer;

    localparam int DW = 32;
    localparam int CW = $clog2(DW + 1);

    logic          s_clk;
    logic          s_rst_n;
    logic          i_spike;
    logic          i_spike_valid;
    logic          i_spike_last;
    logic          o_spike_ready;
    logic [DW-1:0] o_Spikesdata;
    logic          o_Spikesdata_valid;
    logic          i_Spikesdata_ready;
    logic          o_Spikesdata_last;
    logic [CW-1:0] o_word_fill;
    logic [CW-1:0] o_word_ones;

    spike_word_packer #(.DATA_WIDTH(DW)) dut (
        .s_clk              (s_clk),
        .s_rst_n            (s_rst_n),
        .i_spike            (i_spike),
        .i_spike_valid      (i_spike_valid),
        .i_spike_last       (i_spike_last),
        .o_spike_ready      (o_spike_ready),
        .o_Spikesdata       (o_Spikesdata),
        .o_Spikesdata_valid (o_Spikesdata_valid),
        .i_Spikesdata_ready (i_Spikesdata_ready),
        .o_Spikesdata_last  (o_Spikesdata_last),
        .o_word_fill        (o_word_fill),
        .o_word_ones        (o_word_ones)
    );

    // ---------------- clock / reset ----------------
    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    int cyc = 0;
    always @(posedge s_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // The row in progress is a plain queue of bits; a word is emitted when it
    // reaches DW bits or the last flag arrives.
    bit            cur_q[$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            m_fill;
    int            m_ones;
    logic          m_last;

    function automatic logic [DW-1:0] pack_word(input bit q[$], input bit b);
        logic [DW-1:0] w;
        w = '0;
        foreach (q[i]) w[i] = q[i];
        w[q.size()] = b;
        return w;
    endfunction

    function automatic int count_ones(input bit q[$], input bit b);
        int n;
        n = b;
        foreach (q[i]) n += q[i];
        return n;
    endfunction

    always @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            cur_q.delete();
            m_valid <= 1'b0;
            m_data  <= '0;
            m_fill  <= 0;
            m_ones  <= 0;
            m_last  <= 1'b0;
        end else if (i_spike_valid && (!m_valid || i_Spikesdata_ready)) begin
            if (cur_q.size() + 1 == DW || i_spike_last) begin
                m_data  <= pack_word(cur_q, i_spike);
                m_fill  <= cur_q.size() + 1;
                m_ones  <= count_ones(cur_q, i_spike);
                m_last  <= i_spike_last;
                m_valid <= 1'b1;
                cur_q.delete();
            end else begin
                cur_q.push_back(i_spike);
                if (m_valid && i_Spikesdata_ready) m_valid <= 1'b0;
            end
        end else if (m_valid && i_Spikesdata_ready) begin
            m_valid <= 1'b0;
        end
    end

    // ---------------- compare process + completion log ----------------
    logic [DW-1:0] log_data[$];
    int            log_fill[$];
    int            log_ones[$];
    logic          log_last[$];
    int            log_cyc[$];
    int            vcnt = 0;

    always @(negedge s_clk) begin
        check("ready", 64'(o_spike_ready), 64'(!m_valid || i_Spikesdata_ready));
        check("valid", 64'(o_Spikesdata_valid), 64'(m_valid));
        if (m_valid) begin
            check("data", 64'(o_Spikesdata), 64'(m_data));
            check("fill", 64'(o_word_fill), 64'(m_fill));
            check("ones", 64'(o_word_ones), 64'(m_ones));
            check("last", 64'(o_Spikesdata_last), 64'(m_last));
        end
        if (o_Spikesdata_valid) vcnt++;
        if (o_Spikesdata_valid && i_Spikesdata_ready) begin
            log_data.push_back(o_Spikesdata);
            log_fill.push_back(int'(o_word_fill));
            log_ones.push_back(int'(o_word_ones));
            log_last.push_back(o_Spikesdata_last);
            log_cyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    int last_acc_cyc = 0;

    task automatic send_bit(input logic b, input logic l);
        logic acc;
        int   budget;
        budget        = 500;
        acc           = 1'b0;
        i_spike       = b;
        i_spike_last  = l;
        i_spike_valid = 1'b1;
        while (!acc) begin
            @(negedge s_clk);
            acc = o_spike_ready;
            @(posedge s_clk);
            #1;
            budget--;
            if (!acc && budget == 0) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no acceptance expected acceptance within 500 cycles");
                acc = 1'b1;
            end
        end
        last_acc_cyc  = cyc;
        i_spike_valid = 1'b0;
        i_spike_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        i_spike_valid = 1'b0;
        i_spike_last  = 1'b0;
        repeat (n) @(posedge s_clk);
        #1;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_fill.delete();
        log_ones.delete();
        log_last.delete();
        log_cyc.delete();
        vcnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] pat;
        s_rst_n            = 1'b0;
        i_spike            = 1'b0;
        i_spike_valid      = 1'b0;
        i_spike_last       = 1'b0;
        i_Spikesdata_ready = 1'b1;

        repeat (2) @(posedge s_clk);
        #1;
        check("rst_data", 64'(o_Spikesdata), 64'h0);
        check("rst_valid", 64'(o_Spikesdata_valid), 64'h0);
        check("rst_last", 64'(o_Spikesdata_last), 64'h0);
        check("rst_fill", 64'(o_word_fill), 64'h0);
        check("rst_ones", 64'(o_word_ones), 64'h0);
        s_rst_n = 1'b1;
        @(negedge s_clk);
        check("rst_ready", 64'(o_spike_ready), 64'h1);
        @(posedge s_clk);
        #1;

        // Full word, alternating 1,0
        clear_log();
        for (int i = 0; i < DW; i++) send_bit(i % 2 == 0, 1'b0);
        idle(4);
        check("full_count", 64'(log_data.size()), 64'd1);
        if (log_data.size() == 1) begin
            check("full_data", 64'(log_data[0]), 64'h5555_5555);
            check("full_fill", 64'(log_fill[0]), 64'd32);
            check("full_ones", 64'(log_ones[0]), 64'd16);
            check("full_last", 64'(log_last[0]), 64'd0);
            check("full_latency", 64'(log_cyc[0]), 64'(last_acc_cyc));
        end
        check("full_pulse_len", 64'(vcnt), 64'd1);

        // Partial word closed by last
        clear_log();
        send_bit(1, 0); send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 1);
        idle(3);
        check("part_count", 64'(log_data.size()), 64'd1);
        if (log_data.size() == 1) begin
            check("part_data", 64'(log_data[0]), 64'h1B);
            check("part_fill", 64'(log_fill[0]), 64'd5);
            check("part_ones", 64'(log_ones[0]), 64'd4);
            check("part_last", 64'(log_last[0]), 64'd1);
        end

        // Backpressure: 64 ones, downstream stalled for 40 cycles
        clear_log();
        i_Spikesdata_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 2 * DW; i++) send_bit(1'b1, 1'b0);
            end
            begin
                repeat (39) @(posedge s_clk);
                #2;
                check("bp_ready_low", 64'(o_spike_ready), 64'h0);
                check("bp_held_data", 64'(o_Spikesdata), 64'hFFFF_FFFF);
                check("bp_held_valid", 64'(o_Spikesdata_valid), 64'h1);
                @(posedge s_clk);
                #1;
                i_Spikesdata_ready = 1'b1;
            end
        join
        idle(4);
        check("bp_count", 64'(log_data.size()), 64'd2);
        if (log_data.size() == 2) begin
            check("bp_data0", 64'(log_data[0]), 64'hFFFF_FFFF);
            check("bp_data1", 64'(log_data[1]), 64'hFFFF_FFFF);
            check("bp_ones1", 64'(log_ones[1]), 64'd32);
        end

        // Back-to-back full words
        clear_log();
        for (int i = 0; i < 3 * DW; i++) send_bit(1'b1, 1'b0);
        idle(4);
        check("b2b_count", 64'(log_data.size()), 64'd3);
        check("b2b_pulses", 64'(vcnt), 64'd3);
        if (log_data.size() == 3) begin
            check("b2b_gap1", 64'(log_cyc[1] - log_cyc[0]), 64'd32);
            check("b2b_gap2", 64'(log_cyc[2] - log_cyc[1]), 64'd32);
            check("b2b_data2", 64'(log_data[2]), 64'hFFFF_FFFF);
        end

        // Single-bit rows: close and completion coincide every cycle
        clear_log();
        for (int i = 0; i < 4; i++) send_bit(logic'(i % 2), 1'b1);
        idle(3);
        check("row1_count", 64'(log_data.size()), 64'd4);
        check("row1_pulses", 64'(vcnt), 64'd4);
        if (log_data.size() == 4) begin
            check("row1_gap", 64'(log_cyc[3] - log_cyc[0]), 64'd3);
            check("row1_data1", 64'(log_data[1]), 64'h1);
            check("row1_fill", 64'(log_fill[2]), 64'd1);
            check("row1_last", 64'(log_last[3]), 64'd1);
        end

        // Reset in the middle of a word
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
        #1;
        s_rst_n = 1'b0;
        #1;
        check("mid_rst_data", 64'(o_Spikesdata), 64'h0);
        check("mid_rst_valid", 64'(o_Spikesdata_valid), 64'h0);
        check("mid_rst_last", 64'(o_Spikesdata_last), 64'h0);
        check("mid_rst_fill", 64'(o_word_fill), 64'h0);
        check("mid_rst_ones", 64'(o_word_ones), 64'h0);
        repeat (2) @(posedge s_clk);
        #1;
        s_rst_n = 1'b1;
        clear_log();
        pat = 32'h0000_FFFF;
        for (int i = 0; i < DW; i++) send_bit(pat[i], 1'b0);
        idle(3);
        check("post_rst_count", 64'(log_data.size()), 64'd1);
        if (log_data.size() == 1) begin
            check("post_rst_data", 64'(log_data[0]), 64'h0000_FFFF);
            check("post_rst_fill", 64'(log_fill[0]), 64'd32);
            check("post_rst_ones", 64'(log_ones[0]), 64'd16);
        end

        // Randomized traffic with random rows and downstream stalls
        for (int c = 0; c < 3000; c++) begin
            i_spike_valid      = ($urandom_range(0, 3) != 0);
            i_spike            = 1'($urandom_range(0, 1));
            i_spike_last       = ($urandom_range(0, 15) == 0);
            i_Spikesdata_ready = (c % 200 < 20) ? 1'b0 : ($urandom_range(0, 9) < 7);
            @(posedge s_clk);
            #1;
        end
        i_Spikesdata_ready = 1'b1;
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
